// File: rtl/acc_port_sequencer_pkg.sv
// Shared definitions for the accumulator bulk-access sequencer:
// FSM state encoding and command mode constants.
package acc_port_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        TX,
        LD,
        FIN
    } seqState_t;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/acc_port_sequencer.sv
// Bulk dump/load engine for the accumulator register file: streams every entry
// out over tx (dump) or fills every entry from rx (load), lowest address first.
module acc_port_sequencer
    import acc_port_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] accAddress,
    output logic              accWriteEn,
    output logic [DATA_W-1:0] accInData,
    input  logic [DATA_W-1:0] accOutData,
    output logic [DATA_W-1:0] txData,
    output logic              txValid,
    input  logic              txReady,
    input  logic [DATA_W-1:0] rxData,
    input  logic              rxValid,
    output logic              rxReady
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COUNT - 1);

    seqState_t         stateReg, stateNext;
    logic [ADDR_W-1:0] idxReg, idxNext;
    logic              modeReg, modeNext;
    logic [DATA_W-1:0] txDataReg, txDataNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg  <= IDLE;
            idxReg    <= '0;
            modeReg   <= MODE_DUMP;
            txDataReg <= '0;
        end else begin
            stateReg  <= stateNext;
            idxReg    <= idxNext;
            modeReg   <= modeNext;
            txDataReg <= txDataNext;
        end
    end

    assign txData = txDataReg;

    always_comb begin
        stateNext  = stateReg;
        idxNext    = idxReg;
        modeNext   = modeReg;
        txDataNext = txDataReg;
        busy       = 1'b1;
        done       = 1'b0;
        accAddress = '0;
        accWriteEn = 1'b0;
        accInData  = '0;
        txValid    = 1'b0;
        rxReady    = 1'b0;

        case (stateReg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idxNext   = '0;
                    modeNext  = mode;
                    stateNext = (mode == MODE_LOAD) ? LD : RD;
                end
            end
            RD: begin
                // Capture the entry so txData stays stable while tx is stalled
                accAddress = idxReg;
                txDataNext = accOutData;
                stateNext  = TX;
            end
            TX: begin
                txValid = 1'b1;
                if (txReady) begin
                    if (idxReg == LAST_IDX) begin
                        stateNext = FIN;
                    end else begin
                        idxNext   = idxReg + 1'b1;
                        stateNext = RD;
                    end
                end
            end
            LD: begin
                // Write lands on the same edge as the rx handshake
                rxReady    = 1'b1;
                accAddress = idxReg;
                accInData  = rxData;
                accWriteEn = rxValid;
                if (rxValid) begin
                    if (idxReg == LAST_IDX) begin
                        stateNext = FIN;
                    end else begin
                        idxNext = idxReg + 1'b1;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_acc_port_sequencer.sv
// Directed + randomized bench for acc_port_sequencer with a bench-side
// accumulator file and a reference copy of its expected contents.
module tb_acc_port_sequencer;
    import acc_port_sequencer_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic       busy;
    logic       done;
    logic [1:0] accAddress;
    logic       accWriteEn;
    logic [7:0] accInData;
    logic [7:0] accOutData;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;

    logic [7:0] mem [4];
    logic [7:0] refMem [4];
    logic       preWe;
    logic [1:0] preAddr;
    logic [7:0] preData;
    int         doneCount = 0;
    int         wrCount   = 0;
    int         compared  = 0;
    int         mismatched = 0;

    acc_port_sequencer #(.DATA_W(8), .ADDR_W(2), .COUNT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done),
        .accAddress(accAddress), .accWriteEn(accWriteEn),
        .accInData(accInData), .accOutData(accOutData),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator file: combinational read, write on rising edge
    assign accOutData = mem[accAddress];
    always @(posedge clk) begin
        if (accWriteEn) mem[accAddress] <= accInData;
        else if (preWe) mem[preAddr] <= preData;
        if (done) doneCount <= doneCount + 1;
        if (accWriteEn) wrCount <= wrCount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_addr"}, accAddress, 0);
        chk({tag, "_we"}, accWriteEn, 0);
        chk({tag, "_indata"}, accInData, 0);
        chk({tag, "_txdata"}, txData, 0);
        chk({tag, "_txvalid"}, txValid, 0);
        chk({tag, "_rxready"}, rxReady, 0);
    endtask

    // Dump all entries; expected bytes come from refMem in address order.
    task automatic runDump(input int stallIdx, input int stallLen, input bit randStall, input bit pokeStart);
        int dc0, wc0, stall;
        dc0 = doneCount;
        wc0 = wrCount;
        start = 1'b1; mode = MODE_DUMP; txReady = 1'b0;
        tick();
        start = pokeStart; mode = MODE_LOAD;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dump_rd_txvalid", txValid, 0);
            chk("dump_rd_busy", busy, 1);
            chk("dump_rd_addr", accAddress, i);
            tick();
            start = 1'b0;
            stall = randStall ? int'($urandom_range(0, 3)) : ((i == stallIdx) ? stallLen : 0);
            for (int s = 0; s < stall; s++) begin
                #1;
                chk("dump_stall_txvalid", txValid, 1);
                chk("dump_stall_txdata", txData, refMem[i]);
                tick();
            end
            txReady = 1'b1;
            #1;
            chk("dump_tx_valid", txValid, 1);
            chk("dump_tx_data", txData, refMem[i]);
            chk("dump_tx_nowrite", accWriteEn, 0);
            $display("dump byte %0d: txData=0x%02h expected=0x%02h stall=%0d", i, txData, refMem[i], stall);
            tick();
            txReady = 1'b0;
        end
        #1;
        chk("dump_fin_done", done, 1);
        chk("dump_fin_busy", busy, 1);
        tick();
        #1;
        chk("dump_idle_done", done, 0);
        chk("dump_idle_busy", busy, 0);
        chk("dump_done_count", doneCount, dc0 + 1);
        chk("dump_no_writes", wrCount, wc0);
    endtask

    // Load four bytes; abortAfter < 4 pulls reset before that byte is written.
    task automatic runLoad(input logic [7:0] b [4], input int maxGap, input int abortAfter, input bit pokeStart);
        int dc0, wc0, gap;
        dc0 = doneCount;
        wc0 = wrCount;
        start = 1'b1; mode = MODE_LOAD; rxValid = 1'b0;
        tick();
        start = pokeStart; mode = MODE_DUMP;
        for (int i = 0; i < 4; i++) begin
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            rxValid = 1'b0;
            rxData = 8'($urandom);
            for (int g = 0; g < gap; g++) begin
                #1;
                chk("load_gap_rxready", rxReady, 1);
                chk("load_gap_we", accWriteEn, 0);
                chk("load_gap_addr", accAddress, i);
                tick();
                start = 1'b0;
            end
            if (i == abortAfter) begin
                rxValid = 1'b1;
                rxData = ~b[i];
                #1;
                rst = 1'b0;
                #1;
                chkReset("abort");
                tick();
                tick();
                chkReset("abort_hold");
                rst = 1'b1;
                rxValid = 1'b0;
                start = 1'b0;
                chk("abort_no_done", doneCount, dc0);
                chk("abort_writes", wrCount, wc0 + abortAfter);
                $display("load aborted by reset after %0d bytes", abortAfter);
                return;
            end
            rxValid = 1'b1;
            rxData = b[i];
            #1;
            chk("load_we", accWriteEn, 1);
            chk("load_addr", accAddress, i);
            chk("load_indata", accInData, b[i]);
            chk("load_rxready", rxReady, 1);
            $display("load byte %0d: addr=%0d data=0x%02h gap=%0d", i, accAddress, accInData, gap);
            tick();
            start = 1'b0;
            refMem[i] = b[i];
        end
        rxValid = 1'b0;
        #1;
        chk("load_fin_done", done, 1);
        chk("load_fin_busy", busy, 1);
        chk("load_writes", wrCount, wc0 + 4);
        tick();
        #1;
        chk("load_idle_busy", busy, 0);
        chk("load_idle_done", done, 0);
        chk("load_done_count", doneCount, dc0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre [4];
        logic [7:0] bytes [4];
        rst = 1'b0; start = 1'b0; mode = 1'b0; txReady = 1'b0;
        rxData = 8'h00; rxValid = 1'b0;
        preWe = 1'b0; preAddr = 2'd0; preData = 8'h00;
        tick();
        tick();
        chkReset("reset");
        rst = 1'b1;

        // Preload entries directly through the bench-side file
        pre = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            preWe = 1'b1; preAddr = 2'(i); preData = pre[i];
            refMem[i] = pre[i];
            tick();
        end
        preWe = 1'b0;

        runDump(-1, 0, 1'b0, 1'b0);   // no backpressure
        runDump(1, 3, 1'b0, 1'b0);    // 3-cycle stall on second byte
        runDump(-1, 0, 1'b0, 1'b1);   // start+load mode during dump is ignored

        bytes = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
        runLoad(bytes, 0, 99, 1'b0);
        runDump(-1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
        runLoad(bytes, 3, 99, 1'b1);  // gaps, plus ignored start during load
        runDump(-1, 0, 1'b1, 1'b0);

        // Reset mid-load after two bytes; entries 2 and 3 must keep old data
        for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
        runLoad(bytes, 1, 2, 1'b0);
        runDump(-1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
            runLoad(bytes, int'($urandom_range(0, 2)), 99, 1'($urandom));
            runDump(-1, 0, 1'b1, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
